// File: rtl/alu_arbiter_pkg.sv
// Purpose : shared constants for the two-port ALU arbiter (alucontrol codes, flag bit positions).
// Latency : n/a (package only).
// Backpressure: n/a.
package alu_arbiter_pkg;

  // alucontrol codes understood by the shared ALU
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // bit positions inside the 4-bit {overflow,carry,zero,negative} flag vector
  localparam int FLAG_OV = 3;
  localparam int FLAG_C  = 2;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 0;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purpose : combinational 32-bit ALU (add, sub, and, or, slt) with {ov,c,z,n} flags.
// Latency : 0 cycles, purely combinational.
// Backpressure: none; the caller owns all flow control.
// Ports: i_a/i_b operands, i_op alucontrol code, o_result result, o_flags {ov,c,z,n}.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_flags
);

  // op[0] selects subtraction for both SUB and SLT: A + ~B + 1
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_arith;

  assign w_b_eff = i_op[0] ? ~i_b : i_b;
  assign w_sum   = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_op[0]};
  assign w_arith = (i_op == ALU_ADD) || (i_op == ALU_SUB);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD, ALU_SUB: o_result = w_sum[WIDTH-1:0];
      ALU_AND:          o_result = i_a & i_b;
      ALU_OR:           o_result = i_a | i_b;
      // sign of the raw difference, no overflow correction
      ALU_SLT:          o_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1]};
      default:          o_result = '0;
    endcase
  end

  always_comb begin
    o_flags          = '0;
    // carry/overflow only carry meaning for add/sub; forced low otherwise
    o_flags[FLAG_C]  = w_arith & w_sum[WIDTH];
    o_flags[FLAG_OV] = w_arith & ~(i_a[WIDTH-1] ^ w_b_eff[WIDTH-1])
                               &  (i_a[WIDTH-1] ^ w_sum[WIDTH-1]);
    o_flags[FLAG_Z]  = (o_result == '0);
    o_flags[FLAG_N]  = o_result[WIDTH-1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Purpose : round-robin sharing of one combinational ALU between two valid/ready requesters.
// Latency : 1 cycle from request acceptance to registered response; 1 op/cycle total.
// Backpressure: a port's request is only accepted while its response slot is empty or draining.
// Ports: i_clk/i_rst (async active-low), per port p: i_reqP_{valid,a,b,op}/o_reqP_ready,
//        o_rspP_{valid,result,flags}/i_rspP_ready; o_conflict_cnt saturating contention count.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int PRIO_INIT = 0,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic [2:0]       i_req0_op,
  output logic             o_rsp0_valid,
  input  logic             i_rsp0_ready,
  output logic [WIDTH-1:0] o_rsp0_result,
  output logic [3:0]       o_rsp0_flags,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  input  logic [2:0]       i_req1_op,
  output logic             o_rsp1_valid,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp1_result,
  output logic [3:0]       o_rsp1_flags,
  output logic [CNT_W-1:0] o_conflict_cnt
);

  localparam logic PRIO_RST = 1'(PRIO_INIT);

  logic             r_prio;
  logic             r_rsp0_valid, r_rsp1_valid;
  logic [WIDTH-1:0] r_rsp0_result, r_rsp1_result;
  logic [3:0]       r_rsp0_flags, r_rsp1_flags;
  logic [CNT_W-1:0] r_conflict_cnt;

  logic             w_elig0, w_elig1, w_gnt0, w_gnt1;
  logic [WIDTH-1:0] w_alu_a, w_alu_b, w_alu_result;
  logic [2:0]       w_alu_op;
  logic [3:0]       w_alu_flags;

  // eligible = wants to issue and its slot can take new data this cycle;
  // held off while reset is asserted so nothing is accepted during reset
  assign w_elig0 = i_rst & i_req0_valid & (~r_rsp0_valid | i_rsp0_ready);
  assign w_elig1 = i_rst & i_req1_valid & (~r_rsp1_valid | i_rsp1_ready);

  // r_prio names the port that wins a tie
  assign w_gnt0 = w_elig0 & (~w_elig1 | ~r_prio);
  assign w_gnt1 = w_elig1 & (~w_elig0 |  r_prio);

  assign o_req0_ready = w_gnt0;
  assign o_req1_ready = w_gnt1;

  // port 0 is the default selection when nobody is granted
  assign w_alu_a  = w_gnt1 ? i_req1_a  : i_req0_a;
  assign w_alu_b  = w_gnt1 ? i_req1_b  : i_req0_b;
  assign w_alu_op = w_gnt1 ? i_req1_op : i_req0_op;

  alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_op     (w_alu_op),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  // the winner hands priority to the other port; idle cycles keep it
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)      r_prio <= PRIO_RST;
    else if (w_gnt0) r_prio <= 1'b1;
    else if (w_gnt1) r_prio <= 1'b0;
  end

  // response slots: a new grant overrides a same-cycle drain (no bubble)
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_flags  <= '0;
    end else if (w_gnt0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= w_alu_result;
      r_rsp0_flags  <= w_alu_flags;
    end else if (i_rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_flags  <= '0;
    end else if (w_gnt1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= w_alu_result;
      r_rsp1_flags  <= w_alu_flags;
    end else if (i_rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_conflict_cnt <= '0;
    else if (w_elig0 && w_elig1 && (r_conflict_cnt != {CNT_W{1'b1}}))
      r_conflict_cnt <= r_conflict_cnt + 1'b1;
  end

  assign o_rsp0_valid   = r_rsp0_valid;
  assign o_rsp0_result  = r_rsp0_result;
  assign o_rsp0_flags   = r_rsp0_flags;
  assign o_rsp1_valid   = r_rsp1_valid;
  assign o_rsp1_result  = r_rsp1_result;
  assign o_rsp1_flags   = r_rsp1_flags;
  assign o_conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_alu_arbiter.sv
// Purpose : self-checking bench for alu_arbiter: directed scenarios plus randomized traffic vs a reference model.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: response-ready is randomized; pending requests hold their operands until accepted.
module tb_alu_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req0_valid, i_req1_valid;
  logic [31:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
  logic [2:0]  i_req0_op, i_req1_op;
  logic        i_rsp0_ready, i_rsp1_ready;
  logic        o_req0_ready, o_req1_ready;
  logic        o_rsp0_valid, o_rsp1_valid;
  logic [31:0] o_rsp0_result, o_rsp1_result;
  logic [3:0]  o_rsp0_flags, o_rsp1_flags;
  logic [15:0] o_conflict_cnt;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  alu_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_op(i_req0_op),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp0_result(o_rsp0_result), .o_rsp0_flags(o_rsp0_flags),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_op(i_req1_op),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp1_result(o_rsp1_result), .o_rsp1_flags(o_rsp1_flags),
    .o_conflict_cnt(o_conflict_cnt)
  );

  // reference ALU from plain integer arithmetic; returns {result, ov, c, z, n}
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    longint sa, sb, s;
    logic [31:0] r;
    logic ov, c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; ov = 1'b0; c = 1'b0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s  = sa + sb;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd1: begin
        r  = a - b;
        c  = (a >= b);
        s  = sa - sb;
        ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: begin
        r = a - b;
        r = {31'd0, r[31]};
      end
      default: r = 32'd0;
    endcase
    return {r, ov, c, (r == 32'd0), r[31]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom % 4)
      0:       return ($urandom % 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
      1:       return 32'($urandom_range(0, 15));
      2:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    i_req0_valid = 0; i_req1_valid = 0;
    i_req0_a = 0; i_req0_b = 0; i_req0_op = 0;
    i_req1_a = 0; i_req1_b = 0; i_req1_op = 0;
    i_rsp0_ready = 1; i_rsp1_ready = 1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    i_rst = 0;
    @(posedge i_clk); #1;
    i_rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 0;
    i_req0_valid = 1; i_req1_valid = 1;
    repeat (2) @(posedge i_clk);
    #1;
    total++; if (o_rsp0_valid !== 1'b0 || o_rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got %b%b want 00", o_rsp0_valid, o_rsp1_valid); end
    total++; if (o_req0_ready !== 1'b0 || o_req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got %b%b want 00", o_req0_ready, o_req1_ready); end
    total++; if (o_conflict_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", o_conflict_cnt); end
    total++; if (o_rsp0_result !== 32'd0 || o_rsp1_result !== 32'd0 || o_rsp0_flags !== 4'd0 || o_rsp1_flags !== 4'd0) begin
      bad++; $display("FAIL reset_data got %h %h %h %h want zeros", o_rsp0_result, o_rsp1_result, o_rsp0_flags, o_rsp1_flags);
    end
    i_rst = 1;
    @(negedge i_clk);
    total++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin bad++; $display("FAIL reset_first_grant got %b%b want 10", o_req0_ready, o_req1_ready); end
    @(posedge i_clk); #1;
    idle_inputs();
    @(negedge i_clk);
    total++; if (o_conflict_cnt !== 16'd1) begin bad++; $display("FAIL reset_first_cnt got %0d want 1", o_conflict_cnt); end
  endtask

  task automatic test_port0_add();
    apply_reset();
    i_req0_valid = 1; i_req0_a = 5; i_req0_b = 3; i_req0_op = 3'b000;
    @(negedge i_clk);
    total++; if (o_req0_ready !== 1'b1) begin bad++; $display("FAIL p0_add_ready got %b want 1", o_req0_ready); end
    total++; if (o_rsp0_valid !== 1'b0) begin bad++; $display("FAIL p0_add_early got %b want 0", o_rsp0_valid); end
    @(posedge i_clk); #1;
    i_req0_valid = 0;
    @(negedge i_clk);
    total++; if (o_rsp0_valid !== 1'b1 || o_rsp0_result !== 32'd8 || o_rsp0_flags !== 4'b0000) begin
      bad++; $display("FAIL p0_add_rsp got v=%b r=%0d f=%b want v=1 r=8 f=0000", o_rsp0_valid, o_rsp0_result, o_rsp0_flags);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    total++; if (o_rsp0_valid !== 1'b0 || o_rsp0_result !== 32'd8) begin
      bad++; $display("FAIL p0_drain got v=%b r=%0d want v=0 r=8", o_rsp0_valid, o_rsp0_result);
    end
  endtask

  task automatic test_port1_sub_slt();
    apply_reset();
    i_req1_valid = 1; i_req1_a = 7; i_req1_b = 7; i_req1_op = 3'b001;
    @(negedge i_clk);
    total++; if (o_req1_ready !== 1'b1) begin bad++; $display("FAIL p1_sub_ready got %b want 1", o_req1_ready); end
    @(posedge i_clk); #1;
    i_req1_a = 2; i_req1_b = 9; i_req1_op = 3'b101;
    @(negedge i_clk);
    total++; if (o_rsp1_valid !== 1'b1 || o_rsp1_result !== 32'd0 || o_rsp1_flags !== 4'b0110) begin
      bad++; $display("FAIL p1_sub_rsp got v=%b r=%0d f=%b want v=1 r=0 f=0110", o_rsp1_valid, o_rsp1_result, o_rsp1_flags);
    end
    total++; if (o_req1_ready !== 1'b1) begin bad++; $display("FAIL p1_b2b_ready got %b want 1", o_req1_ready); end
    @(posedge i_clk); #1;
    i_req1_valid = 0;
    @(negedge i_clk);
    total++; if (o_rsp1_valid !== 1'b1 || o_rsp1_result !== 32'd1 || o_rsp1_flags !== 4'b0000) begin
      bad++; $display("FAIL p1_slt_rsp got v=%b r=%0d f=%b want v=1 r=1 f=0000", o_rsp1_valid, o_rsp1_result, o_rsp1_flags);
    end
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    apply_reset();
    i_req0_valid = 1; i_req0_a = 100; i_req0_b = 1;
    i_req1_valid = 1; i_req1_a = 200; i_req1_b = 2;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      if (o_rsp0_valid) n0++;
      if (o_rsp1_valid) n1++;
      total++;
      if (o_req0_ready !== ((c % 2) == 0) || o_req1_ready !== ((c % 2) == 1)) begin
        bad++; $display("FAIL contention_grant cycle %0d got %b%b want %0d", c, o_req0_ready, o_req1_ready, c % 2);
      end
      @(posedge i_clk); #1;
    end
    idle_inputs();
    @(negedge i_clk);
    if (o_rsp0_valid) n0++;
    if (o_rsp1_valid) n1++;
    total++; if (n0 != 2 || n1 != 2) begin bad++; $display("FAIL contention_rsp_count got %0d/%0d want 2/2", n0, n1); end
    total++; if (o_conflict_cnt !== 16'd4) begin bad++; $display("FAIL contention_cnt got %0d want 4", o_conflict_cnt); end
    total++; if (o_rsp1_result !== 32'd202) begin bad++; $display("FAIL contention_p1_data got %0d want 202", o_rsp1_result); end
  endtask

  task automatic test_stall();
    int acc0 = 0;
    apply_reset();
    i_rsp0_ready = 0;
    i_req0_valid = 1; i_req0_a = 10; i_req0_b = 20; i_req0_op = 3'b000;
    i_req1_valid = 1; i_req1_op = 3'b010;
    for (int c = 0; c < 6; c++) begin
      i_req1_a = $urandom; i_req1_b = $urandom;
      @(negedge i_clk);
      if (o_req0_ready) acc0++;
      if (c > 0) begin
        total++; if (o_req1_ready !== 1'b1) begin bad++; $display("FAIL stall_p1_grant cycle %0d got %b want 1", c, o_req1_ready); end
        total++; if (o_rsp0_valid !== 1'b1 || o_rsp0_result !== 32'd30) begin
          bad++; $display("FAIL stall_hold cycle %0d got v=%b r=%0d want v=1 r=30", c, o_rsp0_valid, o_rsp0_result);
        end
      end
      @(posedge i_clk); #1;
    end
    total++; if (acc0 != 1) begin bad++; $display("FAIL stall_accepts got %0d want 1", acc0); end
    i_rsp0_ready = 1;
    @(negedge i_clk);
    total++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin bad++; $display("FAIL stall_release got %b%b want 10", o_req0_ready, o_req1_ready); end
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    i_rsp1_ready = 0;
    i_req1_valid = 1; i_req1_a = 1; i_req1_b = 2; i_req1_op = 3'b000;
    @(posedge i_clk); #1;
    i_req1_valid = 0;
    i_req0_valid = 1; i_req0_a = 3; i_req0_b = 4;
    @(posedge i_clk); #1;
    i_req0_valid = 0;
    @(negedge i_clk);
    total++; if (o_rsp1_valid !== 1'b1 || o_rsp1_result !== 32'd3) begin
      bad++; $display("FAIL midrst_pre got v=%b r=%0d want v=1 r=3", o_rsp1_valid, o_rsp1_result);
    end
    #2 i_rst = 0;
    #1;
    total++; if (o_rsp1_valid !== 1'b0 || o_rsp0_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_async got %b%b want 00", o_rsp0_valid, o_rsp1_valid);
    end
    @(posedge i_clk); #1;
    i_rst = 1;
    i_rsp1_ready = 1;
    i_req0_valid = 1; i_req1_valid = 1;
    @(negedge i_clk);
    total++; if (o_req0_ready !== 1'b1 || o_req1_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_prio got %b%b want 10", o_req0_ready, o_req1_ready);
    end
    @(posedge i_clk); #1;
    idle_inputs();
  endtask

  task automatic test_random();
    logic        v[2], rr[2], e[2], g[2], pend[2];
    logic [31:0] a[2], b[2];
    logic [2:0]  op[2];
    logic        ev[2];
    logic [35:0] eres[2];
    logic [2:0]  eop[2];
    logic        o_rdy[2], o_v[2];
    logic [31:0] o_r[2];
    logic [3:0]  o_f[2], m;
    int          fav, cnt;
    apply_reset();
    fav = 0; cnt = 0;
    for (int p = 0; p < 2; p++) begin
      ev[p] = 0; pend[p] = 0; eres[p] = '0; eop[p] = '0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          v[p]  = ($urandom % 4) != 0;
          a[p]  = pick_operand();
          b[p]  = pick_operand();
          op[p] = 3'($urandom_range(0, 7));
        end
        rr[p] = ($urandom % 3) != 0;
      end
      i_req0_valid = v[0]; i_req0_a = a[0]; i_req0_b = b[0]; i_req0_op = op[0]; i_rsp0_ready = rr[0];
      i_req1_valid = v[1]; i_req1_a = a[1]; i_req1_b = b[1]; i_req1_op = op[1]; i_rsp1_ready = rr[1];
      @(negedge i_clk);
      o_rdy[0] = o_req0_ready; o_v[0] = o_rsp0_valid; o_r[0] = o_rsp0_result; o_f[0] = o_rsp0_flags;
      o_rdy[1] = o_req1_ready; o_v[1] = o_rsp1_valid; o_r[1] = o_rsp1_result; o_f[1] = o_rsp1_flags;
      for (int p = 0; p < 2; p++) e[p] = v[p] && (!ev[p] || rr[p]);
      g[0] = e[0] && (!e[1] || fav == 0);
      g[1] = e[1] && (!e[0] || fav == 1);
      for (int p = 0; p < 2; p++) begin
        total++; if (o_rdy[p] !== g[p]) begin bad++; $display("FAIL rnd_ready%0d cycle %0d got %b want %b", p, cyc, o_rdy[p], g[p]); end
        total++; if (o_v[p] !== ev[p]) begin bad++; $display("FAIL rnd_valid%0d cycle %0d got %b want %b", p, cyc, o_v[p], ev[p]); end
        if (ev[p]) begin
          m = (eop[p] <= 3'd1) ? 4'hF : 4'h3;
          total++;
          if (o_r[p] !== eres[p][35:4] || (o_f[p] & m) !== (eres[p][3:0] & m)) begin
            bad++; $display("FAIL rnd_data%0d cycle %0d got %h/%b want %h/%b", p, cyc, o_r[p], o_f[p], eres[p][35:4], eres[p][3:0]);
          end
        end
      end
      total++; if (o_conflict_cnt !== 16'(cnt)) begin bad++; $display("FAIL rnd_cnt cycle %0d got %0d want %0d", cyc, o_conflict_cnt, cnt); end
      for (int p = 0; p < 2; p++) begin
        if (g[p]) begin
          ev[p] = 1; eres[p] = ref_alu(a[p], b[p], op[p]); eop[p] = op[p];
          fav = 1 - p;
        end else if (rr[p]) begin
          ev[p] = 0;
        end
        pend[p] = v[p] && !g[p];
      end
      if (e[0] && e[1] && cnt < 65535) cnt++;
      @(posedge i_clk); #1;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    i_rst = 0;
    test_reset();
    test_port0_add();
    test_port1_sub_slt();
    test_contention();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
